// File: rtl/score_ctrl_if.sv
// Signal bundle between the game engine/keys and score_ctrl: keys, mode and collision in; state, tick and display out.
// Pure wiring with no latency; nothing here can stall, so every signal is a plain level or a one-cycle pulse.
interface score_ctrl_if;
  logic [2:0] KEY;
  logic       Mode_Switch;
  logic       collision;
  logic [1:0] status_led;
  logic       score_tick;
  logic [3:0] digit0;
  logic [3:0] digit1;
  logic [3:0] digit2;
  logic [3:0] digit3;
  logic       show_high;
  logic       new_record;

  modport master (
    output KEY, Mode_Switch, collision,
    input  status_led, score_tick, digit0, digit1, digit2, digit3, show_high, new_record
  );

  modport slave (
    input  KEY, Mode_Switch, collision,
    output status_led, score_tick, digit0, digit1, digit2, digit3, show_high, new_record
  );
endinterface

// File: rtl/score_ctrl.sv
// Dino game flow: IDLE/RUN/OVER FSM, speed-selectable score prescaler, saturating BCD score and high score.
// State and flags change on the edge that samples their cause; digits are combinational from flops; no backpressure.
module score_ctrl #(
  parameter int TICK_DIV    = 50000000,
  parameter int BLINK_TICKS = 2
) (
  input  logic         CLK,
  input  logic         RESET_N,
  score_ctrl_if.slave  bus
);

  localparam int AW = $clog2(TICK_DIV + 2);
  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OVER = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      prev_key_q, prev_key_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic [15:0]     score_q, score_d;
  logic [15:0]     high_q, high_d;
  logic [BW-1:0]   blink_q, blink_d;
  logic            show_high_q, show_high_d;
  logic            new_record_q, new_record_d;
  logic            score_tick_q, score_tick_d;

  logic [2:0]      rise;
  logic [AW-1:0]   acc_step;
  logic [AW-1:0]   acc_sum;
  logic            tick;
  logic [15:0]     disp;

  assign rise     = bus.KEY & ~prev_key_q;
  assign acc_step = bus.Mode_Switch ? AW'(1) : AW'(2);
  assign acc_sum  = acc_q + acc_step;
  assign tick     = (state_q != IDLE) && (acc_sum >= AW'(TICK_DIV));

  // Four-digit BCD increment that sticks at 9999.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    if (v == 16'h9999) begin
      return v;
    end
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (r[4*i +: 4] >= 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (rise[0]) state_d = RUN;
      RUN: begin
        if (rise[1])            state_d = IDLE;
        else if (bus.collision) state_d = OVER;
      end
      OVER:    if (rise[1]) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    prev_key_d   = bus.KEY;
    acc_d        = (state_q == IDLE || state_d == IDLE || tick) ? '0 : acc_sum;
    score_d      = score_q;
    high_d       = high_q;
    blink_d      = blink_q;
    show_high_d  = show_high_q;
    new_record_d = new_record_q;
    score_tick_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise[2]) high_d = '0;
        if (rise[0]) begin
          score_d     = '0;
          show_high_d = 1'b0;
        end
      end
      RUN: begin
        if (rise[1]) begin
          score_d     = '0;
          show_high_d = 1'b1;
        end else if (bus.collision) begin
          // Game ends on this edge; a coincident tick is dropped.
          show_high_d  = 1'b0;
          blink_d      = '0;
          new_record_d = (score_q > high_q);
          if (score_q > high_q) high_d = score_q;
        end else if (tick) begin
          score_d      = bcd_inc(score_q);
          score_tick_d = 1'b1;
        end
      end
      OVER: begin
        if (rise[1]) begin
          score_d      = '0;
          new_record_d = 1'b0;
          show_high_d  = 1'b1;
        end else if (tick) begin
          if (blink_q == BW'(BLINK_TICKS - 1)) begin
            blink_d     = '0;
            show_high_d = ~show_high_q;
          end else begin
            blink_d = blink_q + BW'(1);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      prev_key_q   <= '0;
      acc_q        <= '0;
      score_q      <= '0;
      high_q       <= '0;
      blink_q      <= '0;
      show_high_q  <= 1'b1;
      new_record_q <= 1'b0;
      score_tick_q <= 1'b0;
    end else begin
      prev_key_q   <= prev_key_d;
      acc_q        <= acc_d;
      score_q      <= score_d;
      high_q       <= high_d;
      blink_q      <= blink_d;
      show_high_q  <= show_high_d;
      new_record_q <= new_record_d;
      score_tick_q <= score_tick_d;
    end
  end

  always_comb begin
    disp           = show_high_q ? high_q : score_q;
    bus.status_led = state_q;
    bus.score_tick = score_tick_q;
    bus.show_high  = show_high_q;
    bus.new_record = new_record_q;
    bus.digit0     = disp[15:12];
    bus.digit1     = disp[11:8];
    bus.digit2     = disp[7:4];
    bus.digit3     = disp[3:0];
  end

endmodule

// File: tb/tb_score_ctrl.sv
// Directed bench for score_ctrl with TICK_DIV=8, BLINK_TICKS=2; expectations queued by stimulus, checked by a monitor.
module tb_score_ctrl;
  logic CLK = 1'b0;
  logic RESET_N;
  int   cyc = 0;

  score_ctrl_if bus();

  score_ctrl #(.TICK_DIV(8), .BLINK_TICKS(2)) dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .bus     (bus)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    string       name;
    logic [1:0]  st;
    logic [15:0] dig;
    logic        sh;
    logic        nr;
  } snap_t;

  typedef struct {
    int          cyc;
    logic [15:0] dig;
  } tick_t;

  snap_t snap_q[$];
  tick_t tick_q[$];
  int    vec_cnt = 0;
  int    mis_cnt = 0;

  logic [15:0] shown;
  assign shown = {bus.digit0, bus.digit1, bus.digit2, bus.digit3};

  function automatic logic [15:0] bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic until_cyc(input int t);
    while (cyc < t) step(1);
  endtask

  task automatic exp_snap(input string name, input logic [1:0] st, input logic [15:0] dig,
                          input logic sh, input logic nr);
    snap_t e;
    e.name = name; e.st = st; e.dig = dig; e.sh = sh; e.nr = nr;
    snap_q.push_back(e);
  endtask

  task automatic push_tick(input int c, input logic [15:0] d);
    tick_t t;
    t.cyc = c; t.dig = d;
    tick_q.push_back(t);
  endtask

  task automatic start_game(output int s);
    bus.KEY[0] = 1'b1;
    s = cyc + 1;
    step(1);
    bus.KEY[0] = 1'b0;
  endtask

  // Monitor: state snapshots on request, and every score_tick pulse against the tick queue.
  always @(negedge CLK) begin : mon
    snap_t e;
    tick_t t;
    if (snap_q.size() != 0) begin
      e = snap_q.pop_front();
      vec_cnt++;
      if (bus.status_led !== e.st || shown !== e.dig || bus.show_high !== e.sh || bus.new_record !== e.nr) begin
        mis_cnt++;
        $display("FAIL %s: got st=%0d dig=%h sh=%b nr=%b, want st=%0d dig=%h sh=%b nr=%b",
                 e.name, bus.status_led, shown, bus.show_high, bus.new_record, e.st, e.dig, e.sh, e.nr);
      end
    end
    if (bus.score_tick !== 1'b0) begin
      vec_cnt++;
      if (tick_q.size() == 0) begin
        mis_cnt++;
        $display("FAIL tick_unexpected: got score_tick=%b at cyc %0d dig=%h, want no tick", bus.score_tick, cyc, shown);
      end else begin
        t = tick_q.pop_front();
        if (cyc != t.cyc || shown !== t.dig) begin
          mis_cnt++;
          $display("FAIL tick: got cyc %0d dig=%h, want cyc %0d dig=%h", cyc, shown, t.cyc, t.dig);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish by time %0t, want finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s;
    int r;
    RESET_N         = 1'b0;
    bus.KEY         = 3'b000;
    bus.Mode_Switch = 1'b1;
    bus.collision   = 1'b0;
    exp_snap("reset", 2'd0, bcd(0), 1'b1, 1'b0);
    step(3);
    RESET_N = 1'b1;
    step(1);

    // Game A: normal speed, mid-period switch to fast, run into saturation.
    start_game(s);
    exp_snap("start", 2'd1, bcd(0), 1'b0, 1'b0);
    for (int k = 1; k <= 10; k++) push_tick(s + 8 * k, bcd(k));
    until_cyc(s + 80);
    exp_snap("run_0010", 2'd1, bcd(10), 1'b0, 1'b0);
    step(2);
    bus.Mode_Switch = 1'b0;
    for (int k = 11; k <= 10003; k++) push_tick(s + 85 + 4 * (k - 11), bcd((k > 9999) ? 9999 : k));
    until_cyc(s + 85 + 4 * (10003 - 11));
    exp_snap("saturated", 2'd1, bcd(9999), 1'b0, 1'b0);
    bus.KEY[1] = 1'b1;
    step(1);
    bus.KEY[1] = 1'b0;
    exp_snap("run_abort", 2'd0, bcd(0), 1'b1, 1'b0);

    // Game B: collision coincides with the 42nd tick at score 0041.
    bus.Mode_Switch = 1'b1;
    step(1);
    start_game(s);
    for (int k = 1; k <= 41; k++) push_tick(s + 8 * k, bcd(k));
    until_cyc(s + 335);
    bus.collision = 1'b1;
    step(1);
    bus.collision = 1'b0;
    exp_snap("over_entry", 2'd3, bcd(41), 1'b0, 1'b1);
    until_cyc(s + 340);
    bus.KEY[0] = 1'b1;
    step(1);
    bus.KEY[0] = 1'b0;
    exp_snap("over_key0", 2'd3, bcd(41), 1'b0, 1'b1);
    until_cyc(s + 351);
    exp_snap("blink_0a", 2'd3, bcd(41), 1'b0, 1'b1);
    step(1);
    exp_snap("blink_1a", 2'd3, bcd(41), 1'b1, 1'b1);
    until_cyc(s + 367);
    exp_snap("blink_1b", 2'd3, bcd(41), 1'b1, 1'b1);
    step(1);
    exp_snap("blink_0b", 2'd3, bcd(41), 1'b0, 1'b1);
    bus.KEY[1] = 1'b1;
    step(1);
    bus.KEY[1] = 1'b0;
    exp_snap("over_exit", 2'd0, bcd(41), 1'b1, 1'b0);

    // Game C: fast speed, ends at 0030 below the high score.
    bus.Mode_Switch = 1'b0;
    start_game(s);
    for (int k = 1; k <= 30; k++) push_tick(s + 4 * k, bcd(k));
    until_cyc(s + 121);
    bus.collision = 1'b1;
    step(1);
    bus.collision = 1'b0;
    exp_snap("over_no_record", 2'd3, bcd(30), 1'b0, 1'b0);
    bus.KEY[1] = 1'b1;
    step(1);
    bus.KEY[1] = 1'b0;
    exp_snap("idle_high", 2'd0, bcd(41), 1'b1, 1'b0);

    // Game D: restart during RUN keeps the high score; idle ignores collision; clear high.
    bus.Mode_Switch = 1'b1;
    start_game(s);
    for (int k = 1; k <= 5; k++) push_tick(s + 8 * k, bcd(k));
    until_cyc(s + 40);
    exp_snap("run_0005", 2'd1, bcd(5), 1'b0, 1'b0);
    bus.KEY[1] = 1'b1;
    step(1);
    bus.KEY[1] = 1'b0;
    exp_snap("abort_keep_high", 2'd0, bcd(41), 1'b1, 1'b0);
    bus.collision = 1'b1;
    step(3);
    exp_snap("idle_collision", 2'd0, bcd(41), 1'b1, 1'b0);
    bus.collision = 1'b0;
    step(1);
    bus.KEY[2] = 1'b1;
    step(1);
    bus.KEY[2] = 1'b0;
    exp_snap("clear_high", 2'd0, bcd(0), 1'b1, 1'b0);

    // Game E: asynchronous reset mid-RUN with start key held through release.
    step(1);
    start_game(s);
    push_tick(s + 8, bcd(1));
    push_tick(s + 16, bcd(2));
    until_cyc(s + 20);
    RESET_N    = 1'b0;
    bus.KEY[0] = 1'b1;
    exp_snap("mid_reset", 2'd0, bcd(0), 1'b1, 1'b0);
    step(1);
    RESET_N = 1'b1;
    r = cyc + 1;
    step(1);
    exp_snap("restart", 2'd1, bcd(0), 1'b0, 1'b0);
    for (int k = 1; k <= 3; k++) push_tick(r + 8 * k, bcd(k));
    until_cyc(r + 24);
    exp_snap("one_start", 2'd1, bcd(3), 1'b0, 1'b0);
    bus.KEY[0] = 1'b0;
    step(3);

    while (snap_q.size() != 0) begin
      snap_t e;
      e = snap_q.pop_front();
      vec_cnt++;
      mis_cnt++;
      $display("FAIL %s: got no check, want st=%0d dig=%h", e.name, e.st, e.dig);
    end
    while (tick_q.size() != 0) begin
      tick_t t;
      t = tick_q.pop_front();
      vec_cnt++;
      mis_cnt++;
      $display("FAIL tick_missing: got no tick, want cyc %0d dig=%h", t.cyc, t.dig);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, mis_cnt);
    $finish;
  end
endmodule
